// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned ADDR_LSB        = 2;
  localparam int unsigned DEF_DEPTH_WORDS = 1024;
  localparam int unsigned DEF_LATENCY     = 2;

  // Latency counter is loaded with LATENCY itself, so it must hold that value.
  function automatic int unsigned lat_cnt_w(input int unsigned lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_data,
                                             input logic [3:0]  be);
    logic [31:0] w;
    w = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) w[8*i +: 8] = new_data[8*i +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response channel between the memory stage and the data-memory responder.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, req_pc, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dm_array.sv
// Word storage with per-byte-lane write, combinational read and synchronous clear.
module dm_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (we) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (be[l]) mem[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one access in flight, fixed latency, valid/ready on both channels.
// Optional store trace enabled by defining DM_WRITE_TRACE_EN.
module dm_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int unsigned LATENCY     = DEF_LATENCY
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);

  localparam int unsigned CNT_W = lat_cnt_w(LATENCY);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned WIX_W = 32 - ADDR_LSB;

  if (LATENCY < 1) begin : g_bad_latency
    $error("dm_responder: LATENCY must be at least 1");
  end

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              req_ready_c;
  logic              rsp_valid_c;
  logic              accept;
  logic              commit;
  logic              err_c;
  logic              wr_en;
  logic [31:0]       rd_word;
  logic [31:0]       new_word;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; the counter starts at LATENCY so RESP is entered LATENCY edges after accept
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.req_valid)         next_state = WAIT;
      WAIT:    if (cnt == CNT_W'(1))      next_state = RESP;
      RESP:    if (bus.rsp_ready)         next_state = IDLE;
      default:                            next_state = IDLE;
    endcase
  end

  // Output and control decode
  always_comb begin
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    accept      = 1'b0;
    commit      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_c = ~reset;
        accept      = ~reset & bus.req_valid;
      end
      WAIT:    commit      = ~reset & (cnt == CNT_W'(1));
      RESP:    rsp_valid_c = 1'b1;
      default: ;
    endcase
  end

  assign err_c    = (addr_q[ADDR_LSB-1:0] != '0) ||
                    (addr_q[31:ADDR_LSB] >= WIX_W'(DEPTH_WORDS));
  assign new_word = we_q ? byte_merge(rd_word, wdata_q, be_q) : rd_word;
  assign wr_en    = commit & we_q & ~err_c;

  // Request latch, latency counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= CNT_W'(LATENCY);
        we_q    <= bus.req_we;
        be_q    <= bus.req_be;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (commit) begin
        rdata_q <= err_c ? 32'd0 : new_word;
        err_q   <= err_c;
      end
    end
  end

  dm_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .idx   (addr_q[IDX_W+ADDR_LSB-1:ADDR_LSB]),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (rd_word)
  );

`ifdef DM_WRITE_TRACE_EN
  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (reset)       pc_q <= '0;
    else if (accept) pc_q <= bus.req_pc;
  end

  always_ff @(posedge clk) begin
    if (wr_en) $display("%d@%h: *%h <= %h", $time, pc_q,
                        {addr_q[31:ADDR_LSB], ADDR_LSB'(0)}, new_word);
  end
`else
  logic unused_pc;
  assign unused_pc = ^bus.req_pc;
`endif

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule
